// File: rtl/wordslice_array.sv
// wordslice_array: masked-write word array with registered read port and init sweep
module wordslice_array #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  init_req,
  output logic                  busy,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] DIN,
  input  logic [DATA_WIDTH-1:0] wmask,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] DOUT,
  output logic                  dout_valid
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LAST = (ADDR_WIDTH + 1)'(DEPTH - 1);
  typedef enum logic {INIT, IDLE} state_t;
  state_t                state;
  logic [ADDR_WIDTH:0]   cnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] merged;
  logic                  wr_go, rd_go;
  always_comb begin
    wr_go  = state == IDLE && !init_req && wr_en;
    rd_go  = state == IDLE && !init_req && rd_en;
    merged = (mem[wr_addr] & ~wmask) | (DIN & wmask);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= INIT;
      cnt        <= '0;
      busy       <= 1'b1;
      DOUT       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= rd_go;
      if (rd_go) DOUT <= (wr_go && wr_addr == rd_addr) ? merged : mem[rd_addr];
      if (state == INIT) begin
        cnt   <= cnt == LAST ? '0 : cnt + 1'b1;
        state <= cnt == LAST ? IDLE : INIT;
        busy  <= cnt != LAST;
      end else if (init_req) begin
        cnt   <= '0;
        state <= INIT;
        busy  <= 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst_n && state == INIT) mem[cnt[ADDR_WIDTH-1:0]] <= INIT_VALUE;
    else if (wr_go) mem[wr_addr] <= merged;
  end
endmodule

// File: tb/tb_wordslice_array.sv
// tb_wordslice_array: random and directed checks against a behavioural model
module tb_wordslice_array;
  logic       clk = 0, rst_n = 0, init_req = 0, wr_en = 0, rd_en = 0;
  logic [2:0] wr_addr = 0, rd_addr = 0;
  logic [7:0] din = 0, wmask = 0, dout;
  logic       busy, dout_valid;
  int         total = 0, bad = 0, n;
  logic [7:0] m_mem [8];
  int         sweep_left = 8;
  logic [7:0] e_dout = 0;
  logic       e_valid = 0;
  logic [7:0] fill;
  wordslice_array dut (
    .clk(clk), .rst_n(rst_n), .init_req(init_req), .busy(busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .DIN(din), .wmask(wmask),
    .rd_en(rd_en), .rd_addr(rd_addr), .DOUT(dout), .dout_valid(dout_valid)
  );
  always #5 clk = ~clk;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sweep_left = 8;
      e_dout     = 0;
      e_valid    = 0;
    end else begin
      e_valid = 0;
      if (sweep_left > 0) begin
        m_mem[8 - sweep_left] = 8'h00;
        sweep_left--;
      end else if (init_req) sweep_left = 8;
      else begin
        if (wr_en) m_mem[wr_addr] = (m_mem[wr_addr] & ~wmask) | (din & wmask);
        if (rd_en) begin
          e_dout  = m_mem[rd_addr];
          e_valid = 1;
        end
      end
    end
  end
  always @(negedge clk) begin
    chk("model_busy", busy, sweep_left > 0);
    chk("model_valid", dout_valid, e_valid);
    chk("model_dout", dout, e_dout);
  end
  task automatic op(bit we, logic [2:0] wa, logic [7:0] d, logic [7:0] m, bit re, logic [2:0] ra, bit ir);
    wr_en = we; wr_addr = wa; din = d; wmask = m; rd_en = re; rd_addr = ra; init_req = ir;
    @(negedge clk);
    wr_en = 0; rd_en = 0; init_req = 0;
  endtask
  task automatic count_busy(string nm);
    n = 0;
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(nm, n, 8);
  endtask
  task automatic rd(logic [2:0] a, logic [7:0] exp, string nm);
    op(0, 0, 0, 0, 1, a, 0);
    chk(nm, {dout_valid, dout}, {1'b1, exp});
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("reset_outputs", {busy, dout_valid, dout}, {1'b1, 1'b0, 8'h00});
    rst_n = 1;
    count_busy("sweep_len_release");
    for (int i = 0; i < 8; i++) rd(3'(i), 8'h00, "init_row");
    op(0, 0, 0, 0, 0, 0, 0);
    chk("valid_drops", dout_valid, 0);
    op(1, 2, 8'hA5, 8'hFF, 0, 0, 0);
    rd(2, 8'hA5, "full_write");
    op(1, 2, 8'hFF, 8'h0F, 0, 0, 0);
    rd(2, 8'hAF, "masked_write");
    op(1, 2, 8'h00, 8'h00, 0, 0, 0);
    rd(2, 8'hAF, "zero_mask");
    op(1, 5, 8'h3C, 8'hFF, 1, 5, 0);
    chk("collision", dout, 8'h3C);
    op(1, 4, 8'h77, 8'hFF, 1, 5, 0);
    chk("diff_rows", dout, 8'h3C);
    rd(4, 8'h77, "diff_rows_after");
    for (int i = 0; i < 8; i++) begin
      fill = 8'($urandom) | 8'h01;
      op(1, 3'(i), fill, 8'hFF, 0, 0, 0);
    end
    op(1, 1, 8'hFF, 8'hFF, 1, 1, 1);
    chk("init_req_prio", dout_valid, 0);
    n = 0;
    while (busy && n < 20) begin
      wr_en = 1; wr_addr = 1; din = 8'hFF; wmask = 8'hFF; rd_en = 1; rd_addr = 1;
      @(negedge clk);
      n++;
    end
    wr_en = 0; rd_en = 0;
    chk("sweep_len_req", n, 8);
    for (int i = 0; i < 8; i++) rd(3'(i), 8'h00, "reinit_row");
    rd(4, 8'h00, "read_before_reset");
    op(1, 3, 8'h5A, 8'hFF, 0, 0, 0);
    rd(3, 8'h5A, "read_before_reset2");
    #2 rst_n = 0;
    #1 chk("reset_mid_read", {busy, dout_valid, dout}, {1'b1, 1'b0, 8'h00});
    repeat (2) @(negedge clk);
    rst_n = 1;
    count_busy("sweep_len_after_read_reset");
    op(1, 6, 8'hC3, 8'hFF, 0, 0, 0);
    op(0, 0, 0, 0, 0, 0, 1);
    repeat (2) @(negedge clk);
    #2 rst_n = 0;
    #1 chk("reset_mid_sweep", {busy, dout_valid, dout}, {1'b1, 1'b0, 8'h00});
    repeat (2) @(negedge clk);
    rst_n = 1;
    count_busy("sweep_len_after_sweep_reset");
    rd(6, 8'h00, "row6_swept");
    for (int i = 0; i < 400; i++)
      op(1'($urandom), 3'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 3'($urandom),
         $urandom_range(0, 39) == 0);
    for (int i = 0; i < 20; i++) op(0, 0, 0, 0, 1, 3'(i), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wordslice_array.md
# wordslice_array

Parametrised multi-bit successor to the single-bit memory column. It stores 2**ADDR_WIDTH words of DATA_WIDTH bits and decodes binary write/read addresses internally, replacing the externally driven one-hot word lines. Every write carries a per-bit write mask. A built-in sweep FSM initialises all rows to INIT_VALUE after reset or on request. It sits where the per-bit columns sit today and presents one word-wide read/write port to the datapath controller.

## Interface

- ADDR_WIDTH, 3: address bits; DEPTH = 2**ADDR_WIDTH rows.
- DATA_WIDTH, 8: bits per word, i.e. the number of columns.
- INIT_VALUE, {DATA_WIDTH{1'b0}}: value written to every row by the init sweep.

Clock and reset: one clock; reset is asynchronous and active-low.

- clk  input  1  clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous reset, active low; release is synchronised by the system.
- init_req  input  1  one-cycle request to re-run the init sweep.
- busy  output  1  high while the init sweep runs; requests are dropped.
- wr_en  input  1  write request.
- wr_addr  input  ADDR_WIDTH  row to write.
- DIN  input  DATA_WIDTH  write data.
- wmask  input  DATA_WIDTH  per-bit write enable; 1 = bit updated.
- rd_en  input  1  read request.
- rd_addr  input  ADDR_WIDTH  row to read.
- DOUT  output  DATA_WIDTH  registered read data; holds its value between reads.
- dout_valid  output  1  high for exactly one cycle when DOUT carries new read data.

## Operation

- The array is flop-based, DEPTH x DATA_WIDTH.
  - Array contents are not reset directly; they are defined only by the init sweep.
- The FSM has two states: INIT and IDLE.
- While rst_n is low: state = INIT, sweep counter = 0, busy = 1, DOUT = 0, dout_valid = 0.
- INIT state:
  - Each rising edge writes INIT_VALUE to row[counter], ignoring wmask.
  - After each write the counter increments.
  - The edge that writes row DEPTH-1 moves the FSM to IDLE, clears busy and returns the counter to 0.
- IDLE state:
  - init_req = 1 moves the FSM to INIT with counter 0 on the next edge.
  - init_req has priority over a wr_en or rd_en in the same cycle; those requests are dropped.
- init_req while in INIT is ignored; the sweep does not restart.
- wr_en and rd_en sampled while busy = 1 are dropped.
  - No array write takes place.
  - dout_valid stays 0.
- Write (IDLE, wr_en = 1): row[wr_addr] <= (row[wr_addr] & ~wmask) | (DIN & wmask).
  - wmask = 0 is a legal no-op.
- Read (IDLE, rd_en = 1): DOUT <= row[rd_addr] and dout_valid <= 1.
- Read/write collision (wr_en, rd_en, wr_addr == rd_addr in the same cycle) is write-first:
  - DOUT receives the merged post-write word.
- Simultaneous read and write to different rows: the read returns the pre-edge contents of rd_addr.
- Address arithmetic:
  - Addresses span exactly DEPTH rows, so no out-of-range case exists.
  - The sweep counter is ADDR_WIDTH+1 bits wide, or terminates by compare, so that DEPTH-1 is detected without wrapping.

## Timing

- Read latency is 1 cycle.
  - rd_en is sampled at edge k.
  - DOUT and dout_valid are valid after edge k, for the cycle k..k+1.
- dout_valid drops at edge k+1 unless a new read is accepted at that edge.
- Write latency is 1 cycle: a read of the same row issued in the next cycle sees the new data.
- Back-to-back reads and writes are accepted every cycle; there is no stall outside INIT.
- Init sweep length is exactly DEPTH cycles.
  - busy is high from reset assertion, or from the edge after init_req, until the DEPTH-th sweep edge.
  - A request sampled at the edge where busy falls is still dropped, because busy was high before that edge.
- Reset asserted mid-sweep or mid-read:
  - Outputs go to reset values immediately.
  - The sweep restarts from row 0 after release.
  - Rows already written keep their values until the sweep overwrites them.

## Test plan

All scenarios use ADDR_WIDTH=3, DATA_WIDTH=8, INIT_VALUE=8'h00.

- Release rst_n -> busy = 1 for exactly 8 rising edges, then 0. Reading rows 0..7 returns 8'h00 each, with dout_valid pulsing one cycle per read.
- Write DIN=8'hA5, wmask=8'hFF to addr 2, then read addr 2 the next cycle -> DOUT = 8'hA5 with dout_valid = 1, one cycle after rd_en.
- Masked write DIN=8'hFF, wmask=8'h0F to addr 2 -> read returns 8'hAF. Then write wmask=8'h00 -> read still returns 8'hAF.
- Same cycle: write 8'h3C to addr 5 and read addr 5 -> DOUT = 8'h3C. Same cycle: write 8'h77 to addr 4 and read addr 5 -> DOUT = 8'h3C. A following read of addr 4 -> 8'h77.
- Fill all rows with nonzero data, pulse init_req, and drive wr_en to addr 1 with 8'hFF during busy -> busy high for 8 cycles and the write is dropped. Afterwards all rows read 8'h00.
- Assert rst_n low after 3 sweep edges, hold for 2 cycles, then release -> DOUT = 0, dout_valid = 0, busy = 1 immediately. The sweep takes a full 8 cycles from row 0.
